// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// It drops bytes when full and sets a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH-1:0]   i_data_in,
  input  logic                    i_valid_in,
  output logic [DATA_WIDTH-1:0]   o_data_out,
  output logic                    o_valid_out,
  input  logic                    i_ready_in,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_overflow,
  input  logic                    i_clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  // A pop on the same edge frees the slot a push needs when full.
  always_comb begin
    pop  = !empty_q && i_ready_in;
    push = i_valid_in && (!full_q || pop);
    drop = i_valid_in && !push;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = drop || (ovf_q && !i_clear_overflow);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data_in;
    end
  end

  assign o_data_out  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign o_valid_out = !empty_q;
  assign o_count     = count_q;
  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_uart_rx_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic [DW-1:0] i_data_in = '0;
  logic          i_valid_in = 1'b0;
  logic [DW-1:0] o_data_out;
  logic          o_valid_out;
  logic          i_ready_in = 1'b0;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_overflow;
  logic          i_clear_overflow = 1'b0;

  int nchk = 0;
  int nerr = 0;
  int maxc = 0;

  logic [DW-1:0] q[$];
  bit            movf = 1'b0;
  logic [DW-1:0] popped[$];

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_data_in        (i_data_in),
    .i_valid_in       (i_valid_in),
    .o_data_out       (o_data_out),
    .o_valid_out      (o_valid_out),
    .i_ready_in       (i_ready_in),
    .o_count          (o_count),
    .o_full           (o_full),
    .o_empty          (o_empty),
    .o_overflow       (o_overflow),
    .i_clear_overflow (i_clear_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus an overflow bit.
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q.delete();
      movf = 1'b0;
    end else begin
      bit p, w;
      p = (q.size() > 0) && i_ready_in;
      w = i_valid_in && ((q.size() < DEPTH) || p);
      if (p) void'(q.pop_front());
      if (w) q.push_back(i_data_in);
      if (i_valid_in && !w) movf = 1'b1;
      else if (i_clear_overflow) movf = 1'b0;
    end
  end

  always @(negedge i_clk) begin
    if (!i_reset) begin
      int n;
      n = q.size();
      chk("count", int'(o_count), n);
      chk("valid", int'(o_valid_out), int'(n > 0));
      chk("empty", int'(o_empty), int'(n == 0));
      chk("full", int'(o_full), int'(n == DEPTH));
      chk("data", int'(o_data_out), (n > 0) ? int'(q[0]) : 0);
      chk("overflow", int'(o_overflow), int'(movf));
      if (int'(o_count) > maxc) maxc = int'(o_count);
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d,
                     input bit r, input bit c);
    i_valid_in = v;
    i_data_in = d;
    i_ready_in = r;
    i_clear_overflow = c;
    if (o_valid_out && r) popped.push_back(o_data_out);
    @(negedge i_clk);
    i_valid_in = 1'b0;
    i_ready_in = 1'b0;
    i_clear_overflow = 1'b0;
  endtask

  initial begin
    #1 i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_data", int'(o_data_out), 0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_ovf", int'(o_overflow), 0);

    cyc(1, 8'hA5, 0, 0);
    chk("one_valid", int'(o_valid_out), 1);
    chk("one_data", int'(o_data_out), 'hA5);
    chk("one_count", int'(o_count), 1);
    cyc(0, 8'h00, 1, 0);
    chk("one_pop_empty", int'(o_empty), 1);
    chk("one_pop_data", int'(o_data_out), 0);

    popped.delete();
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    chk("fill_full", int'(o_full), 1);
    chk("fill_count", int'(o_count), 16);

    cyc(1, 8'h55, 0, 0);
    chk("drop_ovf", int'(o_overflow), 1);
    chk("drop_count", int'(o_count), 16);
    chk("drop_head", int'(o_data_out), 0);
    cyc(0, 8'h00, 0, 1);
    chk("clr_ovf", int'(o_overflow), 0);
    cyc(1, 8'h55, 0, 1);
    chk("drop_clr_ovf", int'(o_overflow), 1);
    cyc(0, 8'h00, 0, 1);
    chk("clr2_ovf", int'(o_overflow), 0);

    cyc(1, 8'h10, 1, 0);
    chk("pp_count", int'(o_count), 16);
    chk("pp_ovf", int'(o_overflow), 0);
    chk("pp_head", int'(o_data_out), 'h01);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", int'(o_data_out), i + 1);
      if (i == 15) chk("last_count", int'(o_count), 1);
      cyc(0, 8'h00, 1, 0);
    end
    chk("drain_empty", int'(o_empty), 1);
    chk("order_len", popped.size(), 17);
    for (int i = 0; i < 17; i++)
      if (i < popped.size()) chk("order", int'(popped[i]), i);

    popped.delete();
    for (int i = 0; i < 80; i++)
      cyc(i % 2 == 0, 8'(i / 2), i % 2 == 1, 0);
    chk("wrap_len", popped.size(), 40);
    for (int i = 0; i < 40; i++)
      if (i < popped.size()) chk("wrap_order", int'(popped[i]), i);
    chk("wrap_ovf", int'(o_overflow), 0);
    chk("wrap_max", int'(maxc <= 16), 1);

    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0, 0);
    chk("pre_rst_count", int'(o_count), 5);
    #2 i_reset = 1'b1;
    #1;
    chk("arst_count", int'(o_count), 0);
    chk("arst_valid", int'(o_valid_out), 0);
    chk("arst_data", int'(o_data_out), 0);
    chk("arst_empty", int'(o_empty), 1);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    popped.delete();
    cyc(1, 8'h3C, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("post_rst_len", popped.size(), 1);
    if (popped.size() > 0) chk("post_rst_first", int'(popped[0]), 'h3C);
    chk("post_rst_empty", int'(o_empty), 1);

    repeat (2) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
